// File: rtl/uart_pkg.sv
// uart_pkg: types shared by the UART receiver and the future transmitter.
//   parity_e   : frame parity mode, fixed at elaboration.
//   rx_state_e : receiver FSM states.
//   maj3()     : 3-input majority vote used for bit decisions.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_e;

  // RX_ prefix keeps the state names clear of the PARITY parameter.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: front end of the UART receiver.
//   clk, rst  : system clock, asynchronous active-high reset
//   i_rx      : raw serial line (asynchronous, idle high)
//   o_rx_sync : rx after the 2-flop synchroniser
//   o_maj     : majority of the last three synchronised samples
// All flops reset to 1 so a reset never looks like a start edge.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_sync,
  output logic o_maj
);

  logic [1:0] r_sync;
  logic [2:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_hist <= '1;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_hist <= {r_hist[1:0], r_sync[1]};
    end
  end

  assign o_rx_sync = r_sync[1];
  assign o_maj     = maj3(r_hist);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with majority-voted bit decisions
// and a valid/ready output register.
//   clk, rst      : system clock, asynchronous active-high reset
//   i_rx          : serial line, idle high
//   o_data        : received word, LSB = first data bit on the line
//   o_valid       : o_data and flags valid, held until accepted
//   i_ready       : consumer accepts when o_valid && i_ready
//   o_parity_err  : parity mismatch for the held word
//   o_frame_err   : a stop bit of the held word was decided 0
//   o_overrun     : 1-cycle pulse, a completed frame was dropped
//   o_busy        : FSM not idle
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter parity_e     PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam int unsigned IW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_DECIDE    = TW'(H + 1);
  localparam logic [TW-1:0] T_LAST      = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] I_STOP_LAST = IW'(STOP_BITS - 1);
  localparam bit            HAS_PARITY  = (PARITY != PARITY_NONE);
  localparam bit            PAR_ODD     = (PARITY == PARITY_ODD);

  logic w_rx_sync;
  logic w_maj;
  logic w_decide;
  logic w_frame_now;

  rx_state_e            r_state;
  logic [TW-1:0]        r_timer;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par_acc;
  logic                 r_pend_par;
  logic                 r_pend_frame;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (i_rx),
    .o_rx_sync (w_rx_sync),
    .o_maj     (w_maj)
  );

  assign w_decide    = (r_timer == T_DECIDE);
  // Includes the stop bit being decided right now.
  assign w_frame_now = r_pend_frame | ~w_maj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RX_IDLE;
      r_timer      <= '0;
      r_idx        <= '0;
      r_shreg      <= '0;
      r_par_acc    <= 1'b0;
      r_pend_par   <= 1'b0;
      r_pend_frame <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && i_ready) r_valid <= 1'b0;

      if (r_state != RX_IDLE) r_timer <= (r_timer == T_LAST) ? '0 : r_timer + 1'b1;

      case (r_state)
        RX_IDLE: begin
          r_timer <= '0;
          if (!w_rx_sync) begin
            r_state      <= RX_START;
            r_idx        <= '0;
            r_par_acc    <= 1'b0;
            r_pend_par   <= 1'b0;
            r_pend_frame <= 1'b0;
          end
        end

        RX_START: begin
          if (w_decide) begin
            if (w_maj) begin
              r_state <= RX_IDLE;
              r_timer <= '0;
            end else begin
              r_state <= RX_DATA;
            end
          end
        end

        RX_DATA: begin
          if (w_decide) begin
            r_shreg   <= {w_maj, r_shreg[DATA_BITS-1:1]};
            r_par_acc <= r_par_acc ^ w_maj;
            if (r_idx == I_DATA_LAST) begin
              r_idx   <= '0;
              r_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        RX_PARITY: begin
          if (w_decide) begin
            // Expected bit makes the total ones even (EVEN) or odd (ODD).
            if (w_maj != (r_par_acc ^ PAR_ODD)) r_pend_par <= 1'b1;
            r_state <= RX_STOP;
          end
        end

        RX_STOP: begin
          if (w_decide) begin
            if (r_idx == I_STOP_LAST) begin
              // Return to idle at the decision point, not the bit end,
              // so the next start edge is caught early.
              r_state <= RX_IDLE;
              r_timer <= '0;
              if (!r_valid || i_ready) begin
                r_data      <= r_shreg;
                r_par_err   <= HAS_PARITY && r_pend_par;
                r_frame_err <= w_frame_now;
                r_valid     <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_pend_frame <= w_frame_now;
              r_idx        <= r_idx + 1'b1;
            end
          end
        end

        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_par_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: one 8N1 instance and one 7E2 instance, CLKS_PER_BIT = 16.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx8 = 1'b1, rdy8 = 1'b1, rx7 = 1'b1, rdy7 = 1'b1;
  logic [7:0] d8;
  logic [6:0] d7;
  logic v8, pe8, fe8, ov8, b8;
  logic v7, pe7, fe7, ov7, b7;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .i_rx(rx8), .o_data(d8), .o_valid(v8), .i_ready(rdy8),
    .o_parity_err(pe8), .o_frame_err(fe8), .o_overrun(ov8), .o_busy(b8));

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(PARITY_EVEN), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .i_rx(rx7), .o_data(d7), .o_valid(v7), .i_ready(rdy7),
    .o_parity_err(pe7), .o_frame_err(fe7), .o_overrun(ov7), .o_busy(b7));

  int n_checks = 0;
  int n_err = 0;

  // Observation side: handshakes captured as {ferr, perr, data[8:0]}.
  logic [10:0] q8[$];
  logic [10:0] q7[$];
  int cyc = 0, vcnt8 = 0, vlow8 = 0, ovcnt8 = 0, brise8 = 0;
  int t_busy8 = 0, t_valid8 = 0, t_busy7 = 0, t_valid7 = 0;
  logic pb8 = 1'b0, pv8 = 1'b0, pb7 = 1'b0, pv7 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (v8 && rdy8) q8.push_back({fe8, pe8, 1'b0, d8});
      if (v7 && rdy7) q7.push_back({fe7, pe7, 2'b00, d7});
      if (v8) vcnt8++; else vlow8++;
      if (ov8) ovcnt8++;
      if (b8 && !pb8) begin brise8++; t_busy8 = cyc; end
      if (v8 && !pv8) t_valid8 = cyc;
      if (b7 && !pb7) t_busy7 = cyc;
      if (v7 && !pv7) t_valid7 = cyc;
    end
    pb8 = b8; pv8 = v8; pb7 = b7; pv7 = v7;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference: what the receiver must report for a frame as sent on the line.
  function automatic logic [10:0] model(input int db, input logic [8:0] w, input bit use_par,
                                        input logic par_bit, input int nstop, input logic [1:0] stops);
    int ones = 0;
    logic [8:0] word = '0;
    logic perr, ferr;
    for (int i = 0; i < db; i++) if (w[i]) begin ones++; word[i] = 1'b1; end
    perr = use_par && (((ones + int'(par_bit)) % 2) != 0);
    ferr = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) ferr = 1'b1;
    return {ferr, perr, word};
  endfunction

  function automatic int latency(input int db, input int p, input int nstop);
    return (db + p + nstop) * CPB + CPB / 2 + 2;
  endfunction

  task automatic send(input bit sel, input int db, input logic [8:0] w, input bit use_par,
                      input logic par_bit, input int nstop, input logic [1:0] stops,
                      input int glitch_bit, input int stop_after);
    logic line_bits[$];
    int n = 0;
    line_bits.push_back(1'b0);
    for (int i = 0; i < db; i++) line_bits.push_back(w[i]);
    if (use_par) line_bits.push_back(par_bit);
    for (int i = 0; i < nstop; i++) line_bits.push_back(stops[i]);
    foreach (line_bits[b]) begin
      for (int t = 0; t < CPB; t++) begin
        logic val;
        if (n == stop_after) return;
        val = line_bits[b];
        if (b == glitch_bit && t == CPB / 2) val = ~val;
        if (sel) rx7 = val; else rx8 = val;
        tick(1);
        n++;
      end
    end
    if (sel) rx7 = 1'b1; else rx8 = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic pop(input bit sel, input string tag, input logic [10:0] exp);
    int n = 0;
    logic [10:0] got;
    while ((sel ? q7.size() : q8.size()) == 0 && n < 20 * CPB) begin tick(1); n++; end
    if ((sel ? q7.size() : q8.size()) == 0) begin
      n_checks++;
      assert (0) else begin
        n_err++;
        $error("FAIL %s: observed=no word expected=%0h", tag, exp);
      end
    end else begin
      got = sel ? q7.pop_front() : q8.pop_front();
      check(tag, got, exp);
    end
  endtask

  initial begin
    logic [8:0] w;
    logic pb, bad;
    logic [1:0] st;
    int b0, vc, ov0, vl0, k;

    // Reset state
    tick(3);
    check("rst_data8", d8, 0);
    check("rst_valid8", v8, 0);
    check("rst_perr8", pe8, 0);
    check("rst_ferr8", fe8, 0);
    check("rst_ovr8", ov8, 0);
    check("rst_busy8", b8, 0);
    check("rst_valid7", v7, 0);
    check("rst_busy7", b7, 0);
    rst = 1'b0;
    tick(5);

    // 8N1 0xA5, single-cycle valid, latency
    vcnt8 = 0;
    send(0, 8, 9'h0A5, 0, 1'b0, 1, 2'b11, -1, -1);
    pop(0, "a5_word", model(8, 9'h0A5, 0, 1'b0, 1, 2'b11));
    check("a5_valid_cycles", vcnt8, 1);
    check("a5_latency", t_valid8 - t_busy8, latency(8, 0, 1));

    // Random 8N1 bytes
    for (int i = 0; i < 5; i++) begin
      w = 9'($urandom_range(0, 255));
      send(0, 8, w, 0, 1'b0, 1, 2'b11, -1, -1);
      pop(0, "rand8_word", model(8, w, 0, 1'b0, 1, 2'b11));
    end

    // 7E2: 0x3C with wrong then correct parity
    send(1, 7, 9'h03C, 1, 1'b1, 2, 2'b11, -1, -1);
    pop(1, "3c_badpar", model(7, 9'h03C, 1, 1'b1, 2, 2'b11));
    check("7e2_latency", t_valid7 - t_busy7, latency(7, 1, 2));
    send(1, 7, 9'h03C, 1, 1'b0, 2, 2'b11, -1, -1);
    pop(1, "3c_goodpar", model(7, 9'h03C, 1, 1'b0, 2, 2'b11));

    // Random 7E2 words with random parity correctness and stop values
    for (int i = 0; i < 5; i++) begin
      w   = 9'($urandom_range(0, 127));
      bad = 1'($urandom_range(0, 1));
      st  = 2'($urandom_range(0, 3));
      pb  = (^w[6:0]) ^ bad;
      send(1, 7, w, 1, pb, 2, st, -1, -1);
      pop(1, "rand7_word", model(7, w, 1, pb, 2, st));
    end

    // Framing error then clean frame
    send(0, 8, 9'h055, 0, 1'b0, 1, 2'b00, -1, -1);
    pop(0, "55_ferr", model(8, 9'h055, 0, 1'b0, 1, 2'b00));
    send(0, 8, 9'h0FF, 0, 1'b0, 1, 2'b11, -1, -1);
    pop(0, "ff_after_ferr", model(8, 9'h0FF, 0, 1'b0, 1, 2'b11));

    // False start: 3-clock low glitch on idle line
    b0 = brise8;
    vc = vcnt8;
    rx8 = 1'b0;
    tick(3);
    rx8 = 1'b1;
    tick(40);
    check("glitch_start_seen", brise8 - b0, 1);
    check("glitch_no_word", q8.size(), 0);
    check("glitch_no_valid", vcnt8 - vc, 0);
    check("glitch_back_idle", b8, 0);

    // 1-clock high glitch mid data bit 3 of 0x00
    send(0, 8, 9'h000, 0, 1'b0, 1, 2'b11, 4, -1);
    pop(0, "glitch_00", model(8, 9'h000, 0, 1'b0, 1, 2'b11));

    // Overrun with i_ready low
    rdy8 = 1'b0;
    ov0 = ovcnt8;
    send(0, 8, 9'h011, 0, 1'b0, 1, 2'b11, -1, -1);
    check("hold11_valid", v8, 1);
    check("hold11_data", d8, 8'h11);
    send(0, 8, 9'h022, 0, 1'b0, 1, 2'b11, -1, -1);
    check("ovr_pulses", ovcnt8 - ov0, 1);
    check("ovr_data_held", d8, 8'h11);
    check("ovr_valid_held", v8, 1);

    // Accept 0x11 in the exact completion cycle of 0x33
    vl0 = vlow8;
    fork
      send(0, 8, 9'h033, 0, 1'b0, 1, 2'b11, -1, -1);
      begin
        k = 0;
        while (!b8 && k < 4 * CPB) begin @(negedge clk); k++; end
        repeat (latency(8, 0, 1) - 1) @(posedge clk);
        #2 rdy8 = 1'b1;
        @(posedge clk);
        #2 rdy8 = 1'b0;
      end
    join
    check("same_cycle_valid", v8, 1);
    check("same_cycle_data", d8, 8'h33);
    check("same_cycle_no_gap", vlow8 - vl0, 0);
    check("same_cycle_no_ovr", ovcnt8 - ov0, 1);
    pop(0, "accepted_11", model(8, 9'h011, 0, 1'b0, 1, 2'b11));
    rdy8 = 1'b1;
    pop(0, "accepted_33", model(8, 9'h033, 0, 1'b0, 1, 2'b11));

    // Reset during data bit 4 while a word is held
    rdy8 = 1'b0;
    send(0, 8, 9'h05A, 0, 1'b0, 1, 2'b11, -1, -1);
    check("pre_rst_valid", v8, 1);
    send(0, 8, 9'($urandom_range(0, 255)), 0, 1'b0, 1, 2'b11, -1, 5 * CPB + CPB / 2);
    check("pre_rst_busy", b8, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", v8, 0);
    check("midrst_data", d8, 0);
    check("midrst_busy", b8, 0);
    check("midrst_flags", {pe8, fe8, ov8}, 0);
    rx8 = 1'b1;
    tick(3);
    rst = 1'b0;
    rdy8 = 1'b1;
    tick(5);
    send(0, 8, 9'h081, 0, 1'b0, 1, 2'b11, -1, -1);
    pop(0, "post_rst_81", model(8, 9'h081, 0, 1'b0, 1, 2'b11));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the next generation of the fixed 8N1 receiver. Data width, parity mode and stop-bit count are set at elaboration. Each bit is decided by a 3-sample majority vote. A valid/ready output register carries error flags and signals overrun. It sits between the external RX pin and any byte consumer (FIFO, command parser) in the same clock domain.

## Interface
- CLKS_PER_BIT, 5208: clocks per bit period (50 MHz / 9600 baud); legal range >= 8.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, PARITY_NONE: PARITY_NONE, PARITY_ODD or PARITY_EVEN.
- STOP_BITS, 1: 1 or 2.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_rx  input  1  asynchronous serial line, idle high.
- o_data  output  DATA_BITS  received word, LSB = first data bit on the line.
- o_valid  output  1  o_data and error flags are valid; held until accepted.
- i_ready  input  1  consumer accepts the word when o_valid && i_ready.
- o_parity_err  output  1  parity mismatch for the word in o_data; always 0 when PARITY_NONE.
- o_frame_err  output  1  any stop bit decided as 0 for the word in o_data.
- o_overrun  output  1  one-cycle pulse: a completed frame was dropped.
- o_busy  output  1  high in any state other than IDLE.

## Operation
- Synchroniser: i_rx passes through 2 flops, both reset to 1. A 3-deep shift of the synchronised value feeds a majority function maj.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. H = CLKS_PER_BIT/2 (integer division). Each bit is decided at count H+1 as maj of the samples at H-1, H and H+1.
- FSM states:
  - IDLE: timer held at 0. Synchronised rx = 0 moves to START.
  - START: at decision, maj = 1 is a false start and returns to IDLE with no output. Otherwise go to DATA.
  - DATA: shift decided bits LSB first. After DATA_BITS bits, go to PARITY if PARITY != NONE, else STOP.
  - PARITY: decided bit compared against the XOR of the data bits; ODD expects total ones odd. A mismatch sets a pending parity error.
  - STOP: STOP_BITS decisions; any 0 sets a pending frame error. At the last stop-bit decision, deliver the frame and go to IDLE immediately, without waiting for the bit end, so resync to the next start edge is early.
- Delivery, when a frame completes:
  - If !o_valid, or o_valid && i_ready in the same cycle: load o_data, o_parity_err, o_frame_err; o_valid = 1.
  - If o_valid && !i_ready: drop the new frame, pulse o_overrun for 1 cycle, leave the held word and flags unchanged.
- o_valid clears on the cycle after o_valid && i_ready, unless a new frame loads in that same cycle, in which case it stays 1.
- Frames with errors are still delivered; the flags accompany them.

## Timing
- Reset values: o_data 0, o_valid 0, o_parity_err 0, o_frame_err 0, o_overrun 0, o_busy 0; FSM IDLE; timer 0; synchroniser 1.
- rst asserted mid-frame: all of the above apply immediately and the partial frame is discarded. After release, the first falling edge starts a new frame.
- Edge detect latency: 2 clocks, from the synchroniser.
- o_valid rises 1 clock after the decision cycle of the last stop bit: (1 + DATA_BITS + P + STOP_BITS - 1) × CLKS_PER_BIT + H + 2 clocks after START entry, where P = 1 with parity, else 0.
- Timer width $clog2(CLKS_PER_BIT). Bit index width $clog2(DATA_BITS + 1). No arithmetic overflow is allowed at legal parameter values.
- A low pulse shorter than 2 clocks at the decision point is rejected by the majority vote.

## Structure
- Package uart_pkg: parity enum (PARITY_NONE/ODD/EVEN) and rx FSM state enum (IDLE, START, DATA, PARITY, STOP); shared with the future transmitter.
- Sub-module uart_rx_sampler: 2-flop synchroniser, 3-deep shift and majority output. Reset to all ones.
- Top level: timer, FSM, shift register, output register.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- 8N1, byte 0xA5 with i_ready = 1 → o_data = 0xA5, o_valid for 1 cycle, both error flags 0.
- DATA_BITS = 7, PARITY_EVEN, STOP_BITS = 2, word 0x3C sent with parity bit 1 (wrong) → o_data = 0x3C, o_parity_err = 1. Repeat with correct parity bit 0 → o_parity_err = 0.
- 8N1, 0x55 with stop bit driven 0 → o_frame_err = 1 and the word is delivered. A following 0xFF frame is received cleanly.
- 3-clock low glitch on an idle line → START returns to IDLE, no o_valid. A 1-clock high glitch at mid data bit 3 of 0x00 → o_data = 0x00.
- i_ready = 0, frames 0x11 then 0x22 → o_data holds 0x11 and o_overrun pulses once. Then assert i_ready in the exact completion cycle of 0x33 → o_valid stays 1, o_data = 0x33, no overrun.
- rst asserted during DATA bit 4 → all outputs 0 at once. After release, a 0x81 frame is received correctly.
